control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Parametrised successor to the core/branch/stall control unit.
- Owns the fetch/execute sequencing FSM: normal execution, forward and backward bracket scans with a nesting-depth counter, and a configurable multi-cycle memory stall.
- Sits between instruction fetch and the datapath; drives PC enable/direction and the execute gate.

Parameters:
- DEPTH_W, 8, width of the bracket nesting counter (max depth 2^DEPTH_W-1).
- STALL_CYCLES, 1, idle cycles inserted after a memory-class op; 0 disables the stall state.
- OP_W, 4, instruction opcode width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- instruction  in  OP_W  current opcode (op_code from definitions)
- instr_valid  in  1  instruction is valid this cycle
- acc_zero  in  1  accumulator equals zero
- exec_en  out  1  datapath may execute the current instruction
- pc_en  out  1  PC steps this cycle
- pc_dir  out  1  0 = PC+1, 1 = PC-1
- state_o  out  2  registered FSM state
- depth_o  out  DEPTH_W  registered nesting depth
- busy  out  1  state != CORE
- depth_err  out  1  sticky nesting-overflow flag (optional feature only)

Behaviour:
- States (2-bit enum): CORE=0, SCAN_FWD=1, SCAN_BWD=2, STALL=3.
- Reset (synchronous): state CORE, depth 0, stall count 0, depth_err 0. While reset is high, exec_en=0 and pc_en=0.
- Reset mid-scan or mid-stall aborts the operation; no partial state survives.
- state_o, depth_o, busy and depth_err are registered. exec_en, pc_en and pc_dir are combinational from the current state and inputs.
- Any state except STALL with instr_valid=0: exec_en=0, pc_en=0, no register changes.
- CORE, instr_valid=1:
  - OP_JMPF with acc_zero=1: exec_en=0, pc_en=1, pc_dir=0; next state SCAN_FWD, depth=1.
  - OP_JMPB with acc_zero=0: exec_en=0, pc_en=1, pc_dir=1; next state SCAN_BWD, depth=1.
  - Untaken JMPF/JMPB: exec_en=1, pc_en=1, pc_dir=0; stay in CORE.
  - needs_stall(op) true with STALL_CYCLES>0: exec_en=1, pc_en=1; next state STALL, counter=STALL_CYCLES.
  - All other ops: exec_en=1, pc_en=1, pc_dir=0.
- SCAN_FWD, instr_valid=1: exec_en=0, pc_en=1, pc_dir=0.
  - JMPF: depth+1.
  - JMPB with depth==1: depth 0, next state CORE. PC steps past the matching bracket.
  - JMPB otherwise: depth-1.
- SCAN_BWD: mirror image of SCAN_FWD with pc_dir=1; JMPB increments depth, JMPF decrements.
  - On the match (JMPF with depth==1): pc_dir=0 on that cycle, so PC advances past the matching '['; next state CORE, depth 0.
- STALL: exec_en=0, pc_en=0. The counter decrements every cycle regardless of instr_valid. At count==1, next state CORE.
- Simultaneous events:
  - Stall entry takes no precedence over branches; an op is branch or memory, never both.
  - Acc_zero is sampled only in CORE.
- Depth arithmetic is unsigned DEPTH_W.
- Increment at max depth: saturate without the feature, see Optional Feature with it.

Optional Feature:
- Macro: CTRL_DEPTH_CHECK_EN.
- Defined:
  - An increment at depth 2^DEPTH_W-1 sets depth_err (sticky until reset).
  - Forces state to CORE with depth 0.
  - exec_en and pc_en are held 0 while depth_err=1 (processor halts).
- Undefined:
  - depth_err is tied 0.
  - Depth saturates at max and scanning continues (mismatched matching accepted).

Decomposition:
- definitions package holds:
  - STATE enum (CORE/SCAN_FWD/SCAN_BWD/STALL).
  - op_code values OP_JMPF and OP_JMPB.
  - needs_stall() function.
  - Localparam DEPTH_MAX.
- One sub-module: depth_counter (DEPTH_W-wide up/down/load counter with saturate/overflow output), reused for the stall count with width $clog2(STALL_CYCLES+1).

Test Plan:
- Reset mid-SCAN_FWD at depth 3 -> next cycle state_o=0, depth_o=0, busy=0, pc_en=0 while reset is high.
- CORE, JMPF, acc_zero=1, then stream [JMPF, INC, JMPB, JMPB] -> depth 1,2,2,1,0; returns to CORE after the 2nd JMPB; exec_en=0 throughout the scan.
- CORE, JMPB, acc_zero=0, backward stream [INC, JMPF] -> pc_dir=1 for 2 cycles, pc_dir=0 on the JMPF cycle; state CORE after.
- STALL_CYCLES=3, memory op with instr_valid toggling -> exactly 3 cycles with pc_en=0, then CORE.
- DEPTH_W=2 with CTRL_DEPTH_CHECK_EN, 4 nested JMPF in a forward scan -> depth_err=1, exec_en=0 and pc_en=0 until reset. Without the macro -> depth sticks at 3 and depth_err=0.
- instr_valid=0 in SCAN_BWD for 5 cycles -> depth_o and state_o unchanged, pc_en=0.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: FSM state encoding, opcodes, op classification and default nesting limit.
package control_sequencer_pkg;
  typedef enum logic [1:0] {CORE = 2'd0, SCAN_FWD = 2'd1, SCAN_BWD = 2'd2, STALL = 2'd3} state_t;
  localparam logic [7:0] OP_INC = 8'd0, OP_DEC = 8'd1, OP_LEFT = 8'd2, OP_RIGHT = 8'd3;
  localparam logic [7:0] OP_LD = 8'd4, OP_ST = 8'd5, OP_JMPF = 8'd6, OP_JMPB = 8'd7;
  localparam int DEPTH_MAX = 255;
  function automatic logic needs_stall(input logic [7:0] op);
    return op == OP_LD || op == OP_ST;
  endfunction
endpackage

// File: rtl/control_sequencer_depth_counter.sv
// depth_counter: up/down/load counter that saturates at all-ones and flags increments there.
module depth_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         ovf
);
  logic at_max, at_min;
  assign at_max = cnt == '1;
  assign at_min = cnt == '0;
  assign ovf = inc && !load && at_max;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (inc) cnt <= at_max ? cnt : cnt + 1'b1;
    else if (dec) cnt <= at_min ? cnt : cnt - 1'b1;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/execute sequencing FSM with bracket scans and a multi-cycle memory stall.
// Define CTRL_DEPTH_CHECK_EN to halt on nesting overflow instead of saturating the depth.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int DEPTH_W      = $clog2(DEPTH_MAX + 1),
  parameter int STALL_CYCLES = 1,
  parameter int OP_W         = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    instruction,
  input  logic               instr_valid,
  input  logic               acc_zero,
  output logic               exec_en,
  output logic               pc_en,
  output logic               pc_dir,
  output logic [1:0]         state_o,
  output logic [DEPTH_W-1:0] depth_o,
  output logic               busy,
  output logic               depth_err
);
  localparam int SW = STALL_CYCLES > 0 ? $clog2(STALL_CYCLES + 1) : 1;
  localparam logic [DEPTH_W-1:0] D_ONE = DEPTH_W'(1);
  localparam logic [SW-1:0] S_ONE = SW'(1);
  state_t state, next;
  logic [7:0] op;
  logic jf, jb, mem, halt, d_load, d_inc, d_dec, d_ovf, d_clr, s_load, s_dec, s_ovf, unused_ovf;
  logic [DEPTH_W-1:0] d_val;
  logic [SW-1:0] s_cnt;
  assign op = 8'(instruction);
  assign jf = instr_valid && op == OP_JMPF;
  assign jb = instr_valid && op == OP_JMPB;
  assign mem = instr_valid && needs_stall(op) && STALL_CYCLES > 0;
  assign state_o = state;
`ifdef CTRL_DEPTH_CHECK_EN
  logic err;
  assign halt = err;
  assign d_clr = d_ovf;
  assign depth_err = err;
  assign unused_ovf = s_ovf;
  always_ff @(posedge clk) err <= reset ? 1'b0 : err | d_ovf;
`else
  assign halt = 1'b0;
  assign d_clr = 1'b0;
  assign depth_err = 1'b0;
  assign unused_ovf = s_ovf | d_ovf;
`endif
  always_comb begin
    next = state;
    exec_en = 1'b0;
    pc_en = 1'b0;
    pc_dir = 1'b0;
    d_load = 1'b0;
    d_val = '0;
    d_inc = 1'b0;
    d_dec = 1'b0;
    s_load = 1'b0;
    s_dec = 1'b0;
    if (!reset && !halt)
      case (state)
        CORE: if (instr_valid) begin
          pc_en = 1'b1;
          if (jf && acc_zero) begin
            next = SCAN_FWD;
            d_load = 1'b1;
            d_val = D_ONE;
          end else if (jb && !acc_zero) begin
            next = SCAN_BWD;
            pc_dir = 1'b1;
            d_load = 1'b1;
            d_val = D_ONE;
          end else begin
            exec_en = 1'b1;
            next = mem ? STALL : CORE;
            s_load = mem;
          end
        end
        SCAN_FWD: if (instr_valid) begin
          pc_en = 1'b1;
          d_inc = jf;
          d_dec = jb && depth_o != D_ONE;
          d_load = jb && depth_o == D_ONE;
          next = d_load ? CORE : SCAN_FWD;
        end
        SCAN_BWD: if (instr_valid) begin
          pc_en = 1'b1;
          d_inc = jb;
          d_dec = jf && depth_o != D_ONE;
          d_load = jf && depth_o == D_ONE;
          pc_dir = !d_load;
          next = d_load ? CORE : SCAN_BWD;
        end
        STALL: begin
          s_dec = 1'b1;
          next = s_cnt == S_ONE ? CORE : STALL;
        end
      endcase
  end
  // An overflow with the depth check enabled drops straight back to CORE.
  always_ff @(posedge clk)
    if (reset || d_clr) begin
      state <= CORE;
      busy <= 1'b0;
    end else begin
      state <= next;
      busy <= next != CORE;
    end
  depth_counter #(.W(DEPTH_W)) u_depth (
    .clk(clk), .rst(reset | d_clr), .load(d_load), .load_val(d_val),
    .inc(d_inc), .dec(d_dec), .cnt(depth_o), .ovf(d_ovf)
  );
  depth_counter #(.W(SW)) u_stall (
    .clk(clk), .rst(reset), .load(s_load), .load_val(SW'(STALL_CYCLES)),
    .inc(1'b0), .dec(s_dec), .cnt(s_cnt), .ovf(s_ovf)
  );
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and random checks of control_sequencer against a behavioural model.
module tb_control_sequencer;
  localparam int DW = 2, SC = 3, OW = 4, DMAX = 3;
  localparam logic [3:0] INC = 4'd0, LD = 4'd4, ST = 4'd5, JF = 4'd6, JB = 4'd7;
`ifdef CTRL_DEPTH_CHECK_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif
  logic clk = 1'b0, reset, instr_valid, acc_zero;
  logic [OW-1:0] instruction;
  logic exec_en, pc_en, pc_dir, busy, depth_err;
  logic [1:0] state_o;
  logic [DW-1:0] depth_o;
  int checks = 0, errors = 0;
  int ms, md, mc;
  bit me, xe, xp, xd;

  control_sequencer #(.DEPTH_W(DW), .STALL_CYCLES(SC), .OP_W(OW)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
    .acc_zero(acc_zero), .exec_en(exec_en), .pc_en(pc_en), .pc_dir(pc_dir),
    .state_o(state_o), .depth_o(depth_o), .busy(busy), .depth_err(depth_err)
  );

  always #5 clk = ~clk;

  // Drive inputs and derive the expected combinational outputs for this cycle.
  task automatic apply(input bit r, input bit v, input logic [3:0] op, input bit az);
    reset = r;
    instr_valid = v;
    instruction = op;
    acc_zero = az;
    #1;
    xe = 0;
    xp = 0;
    xd = 0;
    if (!r && !me && v && ms != 3) begin
      xp = 1;
      if (ms == 0) begin
        xe = !((op == JF && az) || (op == JB && !az));
        xd = op == JB && !az;
      end else if (ms == 2) xd = !(op == JF && md == 1);
    end
  endtask

  // Advance one clock and move the model by the rules of the sequencer.
  task automatic clock();
    bit r, v, az;
    int op, open, close;
    r = reset;
    v = instr_valid;
    az = acc_zero;
    op = int'(instruction);
    @(posedge clk);
    #1;
    if (r) begin
      ms = 0; md = 0; mc = 0; me = 0;
    end else if (!me) begin
      if (ms == 0 && v) begin
        if (op == JF && az) begin ms = 1; md = 1; end
        else if (op == JB && !az) begin ms = 2; md = 1; end
        else if (op == LD || op == ST) begin ms = 3; mc = SC; end
      end else if ((ms == 1 || ms == 2) && v) begin
        open = ms == 1 ? JF : JB;
        close = ms == 1 ? JB : JF;
        if (op == open) begin
          if (md < DMAX) md++;
          else if (FEAT) begin me = 1; ms = 0; md = 0; end
        end else if (op == close) begin
          if (md == 1) begin ms = 0; md = 0; end
          else md--;
        end
      end else if (ms == 3) begin
        mc--;
        if (mc == 0) ms = 0;
      end
    end
  endtask

  task automatic test_reset();
    apply(1, 1, INC, 0);
    checks++;
    if (pc_en !== 1'b0 || exec_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb: pc_en=%b exec_en=%b expected 0 0", pc_en, exec_en);
    end
    clock();
    checks++;
    if (state_o !== 2'd0 || depth_o !== '0 || busy !== 1'b0 || depth_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: state=%0d depth=%0d busy=%b err=%b expected 0 0 0 0", state_o, depth_o, busy, depth_err);
    end
    apply(0, 1, JF, 1); clock();
    apply(0, 1, JF, 0); clock();
    apply(0, 1, JF, 1); clock();
    checks++;
    if (state_o !== 2'd1 || depth_o !== 2'd3) begin
      errors++;
      $display("FAIL reset_setup: state=%0d depth=%0d expected 1 3", state_o, depth_o);
    end
    apply(1, 1, JF, 1);
    checks++;
    if (pc_en !== 1'b0 || exec_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_midscan_comb: pc_en=%b exec_en=%b expected 0 0", pc_en, exec_en);
    end
    clock();
    checks++;
    if (state_o !== 2'd0 || depth_o !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_midscan: state=%0d depth=%0d busy=%b expected 0 0 0", state_o, depth_o, busy);
    end
  endtask

  task automatic test_fwd_scan();
    logic [3:0] ops[4] = '{JF, INC, JB, JB};
    int dep[4] = '{2, 2, 1, 0};
    int st[4] = '{1, 1, 1, 0};
    apply(0, 1, JF, 1);
    checks++;
    if (exec_en !== 1'b0 || pc_en !== 1'b1 || pc_dir !== 1'b0) begin
      errors++;
      $display("FAIL fwd_entry: exec/pc/dir=%b%b%b expected 010", exec_en, pc_en, pc_dir);
    end
    clock();
    checks++;
    if (state_o !== 2'd1 || depth_o !== 2'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fwd_entry_regs: state=%0d depth=%0d busy=%b expected 1 1 1", state_o, depth_o, busy);
    end
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, ops[i], 1'($urandom));
      checks++;
      if (exec_en !== 1'b0 || pc_en !== 1'b1 || pc_dir !== 1'b0) begin
        errors++;
        $display("FAIL fwd_scan_comb[%0d]: exec/pc/dir=%b%b%b expected 010", i, exec_en, pc_en, pc_dir);
      end
      clock();
      checks++;
      if (depth_o !== DW'(dep[i]) || state_o !== 2'(st[i])) begin
        errors++;
        $display("FAIL fwd_scan[%0d]: state=%0d depth=%0d expected %0d %0d", i, state_o, depth_o, st[i], dep[i]);
      end
    end
  endtask

  task automatic test_bwd_scan();
    logic [3:0] ops[3] = '{JB, INC, JF};
    bit dir[3] = '{1, 1, 0};
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, ops[i], 1'b0);
      checks++;
      if (exec_en !== 1'b0 || pc_en !== 1'b1 || pc_dir !== dir[i]) begin
        errors++;
        $display("FAIL bwd_scan_comb[%0d]: exec/pc/dir=%b%b%b expected 01%b", i, exec_en, pc_en, pc_dir, dir[i]);
      end
      clock();
    end
    checks++;
    if (state_o !== 2'd0 || depth_o !== '0) begin
      errors++;
      $display("FAIL bwd_scan_end: state=%0d depth=%0d expected 0 0", state_o, depth_o);
    end
  endtask

  task automatic test_stall();
    int n = 0;
    bit done = 0;
    apply(0, 1, ($urandom % 2) ? LD : ST, 1'($urandom));
    checks++;
    if (exec_en !== 1'b1 || pc_en !== 1'b1) begin
      errors++;
      $display("FAIL stall_entry: exec_en=%b pc_en=%b expected 1 1", exec_en, pc_en);
    end
    clock();
    for (int i = 0; i < 10 && !done; i++) begin
      apply(0, 1'(i % 2), INC, 0);
      if (pc_en === 1'b0 && exec_en === 1'b0) n++;
      clock();
      done = state_o === 2'd0;
    end
    checks++;
    if (n != SC || state_o !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_len: idle=%0d state=%0d expected %0d 0", n, state_o, SC);
    end
    apply(0, 1, INC, 0);
    checks++;
    if (pc_en !== 1'b1 || exec_en !== 1'b1) begin
      errors++;
      $display("FAIL stall_resume: pc_en=%b exec_en=%b expected 1 1", pc_en, exec_en);
    end
    clock();
  endtask

  task automatic test_overflow();
    apply(0, 1, JF, 1); clock();
    for (int i = 0; i < 3; i++) begin apply(0, 1, JF, 0); clock(); end
    checks++;
    if (depth_err !== FEAT || depth_o !== (FEAT ? 2'd0 : 2'd3) || state_o !== (FEAT ? 2'd0 : 2'd1)) begin
      errors++;
      $display("FAIL overflow: err=%b depth=%0d state=%0d expected %b %0d %0d", depth_err, depth_o, state_o, FEAT, FEAT ? 0 : 3, FEAT ? 0 : 1);
    end
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, INC, 1'($urandom));
      checks++;
      if (pc_en !== !FEAT || exec_en !== 1'b0) begin
        errors++;
        $display("FAIL overflow_halt[%0d]: pc_en=%b exec_en=%b expected %b 0", i, pc_en, exec_en, !FEAT);
      end
      clock();
    end
    apply(1, 0, INC, 0); clock();
    checks++;
    if (depth_err !== 1'b0 || state_o !== 2'd0) begin
      errors++;
      $display("FAIL overflow_clear: err=%b state=%0d expected 0 0", depth_err, state_o);
    end
  endtask

  task automatic test_bwd_hold();
    apply(0, 1, JB, 0); clock();
    apply(0, 1, JB, 1); clock();
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 4'($urandom), 1'($urandom));
      checks++;
      if (pc_en !== 1'b0 || exec_en !== 1'b0) begin
        errors++;
        $display("FAIL bwd_hold_comb[%0d]: pc_en=%b exec_en=%b expected 0 0", i, pc_en, exec_en);
      end
      clock();
      checks++;
      if (state_o !== 2'd2 || depth_o !== 2'd2) begin
        errors++;
        $display("FAIL bwd_hold[%0d]: state=%0d depth=%0d expected 2 2", i, state_o, depth_o);
      end
    end
    apply(1, 0, INC, 0); clock();
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int i = 0; i < 600; i++) begin
      op = ($urandom % 2) ? (($urandom % 2) ? JF : JB) : 4'($urandom % 10);
      apply(($urandom % 50) == 0, ($urandom % 4) != 0, op, 1'($urandom));
      checks++;
      if (exec_en !== xe || pc_en !== xp || (xp && pc_dir !== xd)) begin
        errors++;
        $display("FAIL rand_comb[%0d]: exec/pc/dir=%b%b%b expected %b%b%b", i, exec_en, pc_en, pc_dir, xe, xp, xd);
      end
      clock();
      checks++;
      if (state_o !== 2'(ms) || depth_o !== DW'(md) || busy !== (ms != 0) || depth_err !== me) begin
        errors++;
        $display("FAIL rand_regs[%0d]: state=%0d depth=%0d busy=%b err=%b expected %0d %0d %b %b", i, state_o, depth_o, busy, depth_err, ms, md, ms != 0, me);
      end
    end
  endtask

  initial begin
    ms = 0; md = 0; mc = 0; me = 0;
    test_reset();
    test_fwd_scan();
    test_bwd_scan();
    test_stall();
    test_overflow();
    test_bwd_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
